eprisc_ttl_uart_tx: RTL

Byte-oriented 8N1 UART transmitter that drives the I/O controller's `oTTLSerialTX` line. It is the transmit-side counterpart to the TTL serial receive path. Bytes written from the controller's register side are queued in an 8-entry FIFO. They are shifted out LSB-first at a fixed bit period of `CLOCKS_PER_BIT` board clocks, so the bench-side serial monitor can decode them with the same 1024-time-unit bit window used for RX stimulus.

---
 rtl/eprisc_ttl_uart_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/eprisc_ttl_uart_tx.sv
// 8N1 UART transmitter driving oTTLSerialTX from a small byte FIFO.
// Bytes leave LSB-first, one bit per CLOCKS_PER_BIT clocks, with no gap between queued frames.
module eprisc_ttl_uart_tx #(
   parameter int unsigned CLOCKS_PER_BIT  = 256,
   parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
   input  logic                     iBoardClock,
   input  logic                     iBoardReset,
   input  logic [7:0]               iTxData,
   input  logic                     iTxWrite,
   input  logic                     iTxHold,
   output logic                     oTTLSerialTX,
   output logic                     oTxFull,
   output logic                     oTxEmpty,
   output logic [FIFO_DEPTH_LOG2:0] oTxCount,
   output logic                     oTxBusy,
   output logic                     oTxDone
);
   localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned BAUD_MAX  = CLOCKS_PER_BIT - 1;
   localparam logic [15:0] BAUD_LAST = BAUD_MAX[15:0];
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = DEPTH[FIFO_DEPTH_LOG2:0];
   localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                     state_q, state_d;
   logic [15:0]                baud_q, baud_d;
   logic [2:0]                 bit_q, bit_d;
   logic [7:0]                 shift_q, shift_d;
   logic                       tx_q, tx_d;
   logic [7:0]                 mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
   logic                       full, empty, push, pop, baud_done;

   // Full is taken from the registered count, so a pop never frees a slot for a same-cycle write.
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   assign push      = iTxWrite && !full;
   assign baud_done = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty && !iTxHold) begin
               state_d = START;
               pop     = 1'b1;
            end
         end
         START: begin
            if (baud_done) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (baud_done) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (baud_done) begin
               if (!empty && !iTxHold) begin
                  state_d = START;
                  pop     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) shift_d = mem_q[rd_ptr_q];

      baud_d = (state_d != state_q || baud_done || state_q == IDLE) ? '0 : baud_q + 16'd1;

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;

      // Line is computed from the next state so it changes on the same edge as the FSM.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge iBoardClock) begin
      if (iBoardReset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge iBoardClock) begin
      shift_q <= shift_d;
      if (push) mem_q[wr_ptr_q] <= iTxData;
   end

   assign oTTLSerialTX = tx_q;
   assign oTxFull      = full;
   assign oTxEmpty     = empty;
   assign oTxCount     = count_q;
   assign oTxBusy      = (state_q != IDLE);
   assign oTxDone      = (state_q == STOP) && baud_done;
endmodule
